// File: rtl/arith_seq_pkg.sv
// Shared encodings for the multi-cycle arithmetic sequencer.
package arith_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_POW = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    localparam int ADD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/arith_iter_step.sv
// One iteration of shift-add multiply (LSB first) or restoring divide (MSB first).
module arith_iter_step #(
    parameter int WIDTH = 16
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] part,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] part_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum       = {1'b0, acc} + (part[0] ? {1'b0, opnd} : '0);
        trial     = {acc, part[WIDTH-1]};
        diff      = trial - {1'b0, opnd};
        acc_next  = '0;
        part_next = '0;
        if (div_mode) begin
            // acc is the partial remainder, part shifts dividend out and quotient in
            if (trial >= {1'b0, opnd}) begin
                acc_next  = diff[WIDTH-1:0];
                part_next = {part[WIDTH-2:0], 1'b1};
            end else begin
                acc_next  = trial[WIDTH-1:0];
                part_next = {part[WIDTH-2:0], 1'b0};
            end
        end else begin
            // {carry, acc, part} shifts right; part ends up holding the low product bits
            acc_next  = sum[WIDTH:1];
            part_next = {sum[0], part[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/arith_op_sequencer.sv
// Sequences one shared shift/add datapath through ADD, SUB, XOR, MUL, DIV and POW.
module arith_op_sequencer
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   part;
    logic [CNT_W-1:0]   cnt;
    logic [EXP_W-1:0]   pass;
    logic [EXP_W-1:0]   e_r;

    logic               div_mode;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   part_next;

    logic               fin;
    logic               step_en;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   fin_rem;
    logic               fin_err;

    assign div_mode = (op_r == OP_DIV);
    assign opnd     = div_mode ? b_r : a_r;

    arith_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_mode  (div_mode),
        .acc       (acc),
        .part      (part),
        .opnd      (opnd),
        .acc_next  (acc_next),
        .part_next (part_next)
    );

    // Decide, for the current EXEC cycle, whether to finish or take another step.
    always_comb begin
        fin     = 1'b0;
        step_en = 1'b0;
        fin_res = '0;
        fin_rem = '0;
        fin_err = 1'b0;
        if (state == ST_EXEC) begin
            case (op_r)
                OP_ADD: begin fin = 1'b1; fin_res = a_r + b_r; end
                OP_SUB: begin fin = 1'b1; fin_res = a_r - b_r; end
                OP_XOR: begin fin = 1'b1; fin_res = a_r ^ b_r; end
                OP_MUL: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        fin     = 1'b1;
                        fin_res = part;
                    end else begin
                        step_en = 1'b1;
                    end
                end
                OP_DIV: begin
                    if (b_r == '0) begin
                        fin     = 1'b1;
                        fin_res = '1;
                        fin_rem = a_r;
                        fin_err = 1'b1;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        fin     = 1'b1;
                        fin_res = part;
                        fin_rem = acc;
                    end else begin
                        step_en = 1'b1;
                    end
                end
                OP_POW: begin
                    if (pass == e_r) begin
                        fin     = 1'b1;
                        fin_res = part;
                    end else begin
                        step_en = 1'b1;
                    end
                end
                default: begin fin = 1'b1; fin_err = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rem    <= '0;
            err    <= 1'b0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            part   <= '0;
            cnt    <= '0;
            pass   <= '0;
            e_r    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_EXEC;
                        busy  <= 1'b1;
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        pass  <= '0;
                        e_r   <= b[EXP_W-1:0];
                        // part seeds the multiplier, the dividend, or the POW accumulator
                        if (op == OP_DIV)
                            part <= a;
                        else if (op == OP_POW)
                            part <= WIDTH'(1);
                        else
                            part <= b;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (fin) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= fin_res;
                        rem    <= fin_rem;
                        err    <= fin_err;
                    end else if (step_en) begin
                        acc  <= acc_next;
                        part <= part_next;
                        cnt  <= cnt + 1'b1;
                        if (op_r == OP_POW && cnt == CNT_W'(WIDTH - 1)) begin
                            state <= ST_LOAD;
                            pass  <= pass + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // last product stays in part as the next multiplier
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_EXEC;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Randomized and directed bench for arith_op_sequencer against a plain-arithmetic model.
module tb_arith_op_sequencer;
    import arith_seq_pkg::*;

    localparam int W     = 16;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  rem;
    logic          err;

    int checks = 0;
    int errors = 0;

    arith_op_sequencer #(.WIDTH(16), .EXP_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rem    (rem),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] m,
                                  output logic e, output int lat);
        logic [31:0] p;
        int ex;
        r = '0; m = '0; e = 1'b0; lat = ADD_LAT;
        case (o)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd5: r = x ^ y;
            3'd2: begin p = x * y; r = p[W-1:0]; lat = W + 1; end
            3'd3: begin
                if (y == 0) begin r = '1; m = x; e = 1'b1; end
                else begin r = x / y; m = x % y; lat = W + 1; end
            end
            3'd4: begin
                ex = int'(y[3:0]);
                r  = 1;
                for (int i = 0; i < ex; i++) begin p = r * x; r = p[W-1:0]; end
                lat = 1 + ex * (W + 1);
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er, em;
        logic ee;
        int elat, k;
        logic busy_ok;
        model(o, x, y, er, em, ee, elat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        busy_ok = busy;
        k = 0;
        while (k < LIMIT) begin
            tick();
            k++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'(k), 32'(elat));
        end else begin
            chk({tag, "_lat"}, 32'(k), 32'(elat));
            chk({tag, "_res"}, 32'(result), 32'(er));
            chk({tag, "_rem"}, 32'(rem), 32'(em));
            chk({tag, "_err"}, 32'(err), 32'(ee));
            chk({tag, "_busyhold"}, 32'(busy_ok), 32'd1);
            chk({tag, "_busydone"}, 32'(busy), 32'd0);
            tick();
            chk({tag, "_pulse"}, 32'(done), 32'd0);
            chk({tag, "_holdres"}, 32'(result), 32'(er));
        end
    endtask

    initial begin
        int k;
        logic seen;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b1; op = OP_MUL; a = 16'd5; b = 16'd7;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("mul3x4", OP_MUL, 16'd3, 16'd4);
        chk("mul3x4_const", 32'(result), 32'd12);
        run_op("div6_4", OP_DIV, 16'd6, 16'd4);
        chk("div6_4_const", 32'(rem), 32'd2);
        run_op("div9_0", OP_DIV, 16'd9, 16'd0);
        run_op("sub4_3", OP_SUB, 16'd4, 16'd3);
        run_op("sub3_4", OP_SUB, 16'd3, 16'd4);
        chk("sub3_4_const", 32'(result), 32'h0000FFFF);
        run_op("add3_4", OP_ADD, 16'd3, 16'd4);
        run_op("xor", OP_XOR, 16'h00F0, 16'h0FF0);
        chk("xor_const", 32'(result), 32'h00000F00);
        run_op("pow4_2", OP_POW, 16'd4, 16'd2);
        run_op("pow_e0", OP_POW, 16'd9, 16'd0);
        run_op("pow2_15", OP_POW, 16'd2, 16'd15);
        chk("pow2_15_const", 32'(result), 32'h00008000);
        run_op("illegal7", 3'd7, 16'd1, 16'd2);
        run_op("illegal6", 3'd6, 16'd3, 16'd2);

        // start while busy is dropped; held start is taken right after done
        @(negedge clk);
        op = OP_MUL; a = 16'd3; b = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op = OP_ADD; a = 16'd1; b = 16'd1; start = 1'b1;
        k = 2;
        while (k < LIMIT) begin
            tick();
            k++;
            if (done) break;
        end
        chk("bb_lat", 32'(k), 32'd17);
        chk("bb_first_res", 32'(result), 32'd12);
        chk("bb_first_err", 32'(err), 32'd0);
        tick();
        start = 1'b0;
        chk("bb_accept_busy", 32'(busy), 32'd1);
        chk("bb_accept_done", 32'(done), 32'd0);
        tick();
        chk("bb_second_done", 32'(done), 32'd1);
        chk("bb_second_res", 32'(result), 32'd2);
        tick();

        // reset in the middle of a MUL
        @(negedge clk);
        op = OP_MUL; a = 16'd3; b = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_rem", 32'(rem), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("mrst_quiet", 32'(seen), 32'd0);
        run_op("post_rst_add", OP_ADD, 16'd100, 16'd23);

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
